// File: rtl/mem_protect_multi_pkg.sv
// Shared types for the N-region execution monitor: per-region FSM state encoding and
// violation source codes used by the optional capture logic.
package mem_protect_multi_pkg;

    typedef enum logic [1:0] {
        MP_ABORT = 2'd0,
        MP_RUN   = 2'd1,
        MP_DONE  = 2'd2
    } mp_state_e;

    localparam logic MP_SRC_CPU = 1'b0;
    localparam logic MP_SRC_DMA = 1'b1;

endpackage

// File: rtl/mem_protect_multi_if.sv
// Snooped core bus: program counter plus CPU and DMA write strobes/addresses.
// The core side drives it (master); the monitor only observes it (slave).
interface mem_protect_multi_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] data_addr;
    logic              data_en;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_en;

    modport master (output pc, data_addr, data_en, dma_addr, dma_en);
    modport slave  (input  pc, data_addr, data_en, dma_addr, dma_en);
endinterface

// File: rtl/mem_protect_multi_region_fsm.sv
// One ER/PR pair: address compares, ABORT/RUN/DONE tracker and registered violation pulse.
// With MEM_PROTECT_VIOL_CAPTURE_EN the per-source hit terms are exported for capture.
module mem_protect_multi_region_fsm
    import mem_protect_multi_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_en,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_en,
    input  logic [ADDR_W-1:0] er_min,
    input  logic [ADDR_W-1:0] er_max,
    input  logic [ADDR_W-1:0] pr_min,
    input  logic [ADDR_W-1:0] pr_max,
    output logic              exec,
    output logic              viol,
    output logic              viol_next
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
    ,
    output logic              cpu_hit,
    output logic              dma_hit
`endif
);

    mp_state_e state_reg, state_next;
    logic      viol_reg;
    logic      cpu_hit_w, dma_hit_w, hit, at_entry, at_exit, in_er;

    assign cpu_hit_w = data_en && (data_addr >= pr_min) && (data_addr <= pr_max);
    assign dma_hit_w = dma_en  && (dma_addr  >= pr_min) && (dma_addr  <= pr_max);
    assign hit       = cpu_hit_w || dma_hit_w;
    assign at_entry  = (pc == er_min);
    assign at_exit   = (pc == er_max);
    assign in_er     = (pc >= er_min) && (pc <= er_max);

    // A protected write always wins over entry/exit progress in the same cycle.
    always_comb begin
        state_next = state_reg;
        viol_next  = 1'b0;
        if (!en) begin
            state_next = MP_ABORT;
        end else begin
            case (state_reg)
                MP_ABORT: if (at_entry && !hit) state_next = MP_RUN;
                MP_RUN: begin
                    if (hit || !in_er) begin
                        state_next = MP_ABORT;
                        viol_next  = 1'b1;
                    end else if (at_exit) begin
                        state_next = MP_DONE;
                    end
                end
                MP_DONE: begin
                    if (hit) begin
                        state_next = MP_ABORT;
                        viol_next  = 1'b1;
                    end else if (at_entry) begin
                        state_next = MP_RUN;
                    end
                end
                default: state_next = MP_ABORT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= MP_ABORT;
            viol_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            viol_reg  <= viol_next;
        end
    end

    assign exec = (state_reg == MP_DONE);
    assign viol = viol_reg;

`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
    assign cpu_hit = cpu_hit_w;
    assign dma_hit = dma_hit_w;
`endif

endmodule

// File: rtl/mem_protect_multi.sv
// N-region attested-execution monitor: per-region trackers, saturating violation-cycle counter,
// and first-violation capture registers when MEM_PROTECT_VIOL_CAPTURE_EN is defined.
module mem_protect_multi
    import mem_protect_multi_pkg::*;
#(
    parameter int  NUM_REGIONS = 4,
    parameter int  ADDR_W      = 16,
    parameter int  CNT_W       = 8,
    localparam int RGN_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    mem_protect_multi_if.slave            bus,
    input  logic [NUM_REGIONS*ADDR_W-1:0] er_min_flat,
    input  logic [NUM_REGIONS*ADDR_W-1:0] er_max_flat,
    input  logic [NUM_REGIONS*ADDR_W-1:0] pr_min_flat,
    input  logic [NUM_REGIONS*ADDR_W-1:0] pr_max_flat,
    input  logic [NUM_REGIONS-1:0]        region_en,
    output logic [NUM_REGIONS-1:0]        exec,
    output logic [NUM_REGIONS-1:0]        viol,
    output logic [CNT_W-1:0]              viol_cnt
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]             viol_addr,
    output logic                          viol_src,
    output logic [RGN_W-1:0]              viol_rgn,
    output logic                          viol_vld,
    input  logic                          viol_clr
`endif
);

    logic [NUM_REGIONS-1:0] viol_next;
    logic                   any_viol;
    logic [CNT_W-1:0]       viol_cnt_reg;
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
    logic [NUM_REGIONS-1:0] cpu_hit, dma_hit;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            mem_protect_multi_region_fsm #(.ADDR_W(ADDR_W)) u_fsm (
                .clk       (clk),
                .rst       (rst),
                .en        (region_en[gi]),
                .pc        (bus.pc),
                .data_addr (bus.data_addr),
                .data_en   (bus.data_en),
                .dma_addr  (bus.dma_addr),
                .dma_en    (bus.dma_en),
                .er_min    (er_min_flat[gi*ADDR_W +: ADDR_W]),
                .er_max    (er_max_flat[gi*ADDR_W +: ADDR_W]),
                .pr_min    (pr_min_flat[gi*ADDR_W +: ADDR_W]),
                .pr_max    (pr_max_flat[gi*ADDR_W +: ADDR_W]),
                .exec      (exec[gi]),
                .viol      (viol[gi]),
                .viol_next (viol_next[gi])
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
                ,
                .cpu_hit   (cpu_hit[gi]),
                .dma_hit   (dma_hit[gi])
`endif
            );
        end
    endgenerate

    // Counts violation cycles, not violating regions.
    assign any_viol = |viol_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt_reg <= '0;
        end else if (any_viol && (viol_cnt_reg != {CNT_W{1'b1}})) begin
            viol_cnt_reg <= viol_cnt_reg + CNT_W'(1);
        end
    end

    assign viol_cnt = viol_cnt_reg;

`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
    logic [ADDR_W-1:0] cap_addr_next, viol_addr_reg;
    logic              cap_src_next, viol_src_reg, viol_vld_reg;
    logic [RGN_W-1:0]  cap_rgn_next, viol_rgn_reg;

    // Descending scan so the lowest violating region is the one reported; CPU wins over DMA,
    // and a violation with no write behind it was an exit from ER, reported as pc.
    always_comb begin
        cap_rgn_next  = '0;
        cap_addr_next = bus.pc;
        cap_src_next  = MP_SRC_CPU;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (viol_next[i]) begin
                cap_rgn_next = RGN_W'(i);
                if (cpu_hit[i]) begin
                    cap_addr_next = bus.data_addr;
                    cap_src_next  = MP_SRC_CPU;
                end else if (dma_hit[i]) begin
                    cap_addr_next = bus.dma_addr;
                    cap_src_next  = MP_SRC_DMA;
                end else begin
                    cap_addr_next = bus.pc;
                    cap_src_next  = MP_SRC_CPU;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_addr_reg <= '0;
            viol_src_reg  <= 1'b0;
            viol_rgn_reg  <= '0;
            viol_vld_reg  <= 1'b0;
        end else if (any_viol && (!viol_vld_reg || viol_clr)) begin
            viol_addr_reg <= cap_addr_next;
            viol_src_reg  <= cap_src_next;
            viol_rgn_reg  <= cap_rgn_next;
            viol_vld_reg  <= 1'b1;
        end else if (viol_clr) begin
            viol_vld_reg  <= 1'b0;
        end
    end

    assign viol_addr = viol_addr_reg;
    assign viol_src  = viol_src_reg;
    assign viol_rgn  = viol_rgn_reg;
    assign viol_vld  = viol_vld_reg;
`endif

endmodule

// File: tb/tb_mem_protect_multi.sv
// Bench for mem_protect_multi: directed walk, vector table, async reset, then random traffic
// against a region-progress model; a CNT_W=2 copy shares the stimulus to cover saturation.
module tb_mem_protect_multi;

    localparam int N  = 4;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_protect_multi_if #(.ADDR_W(AW)) bus ();

    logic [N*AW-1:0] er_min_flat, er_max_flat, pr_min_flat, pr_max_flat;
    logic [N-1:0]    region_en, exec, viol, exec2, viol2;
    logic [7:0]      viol_cnt;
    logic [1:0]      viol_cnt2;
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
    logic [AW-1:0]   viol_addr, viol_addr2;
    logic            viol_src, viol_src2, viol_vld, viol_vld2, viol_clr;
    logic [1:0]      viol_rgn, viol_rgn2;
`endif

    mem_protect_multi #(.NUM_REGIONS(N), .ADDR_W(AW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .er_min_flat(er_min_flat), .er_max_flat(er_max_flat),
        .pr_min_flat(pr_min_flat), .pr_max_flat(pr_max_flat),
        .region_en(region_en), .exec(exec), .viol(viol), .viol_cnt(viol_cnt)
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
        , .viol_addr(viol_addr), .viol_src(viol_src), .viol_rgn(viol_rgn),
        .viol_vld(viol_vld), .viol_clr(viol_clr)
`endif
    );

    mem_protect_multi #(.NUM_REGIONS(N), .ADDR_W(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus),
        .er_min_flat(er_min_flat), .er_max_flat(er_max_flat),
        .pr_min_flat(pr_min_flat), .pr_max_flat(pr_max_flat),
        .region_en(region_en), .exec(exec2), .viol(viol2), .viol_cnt(viol_cnt2)
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
        , .viol_addr(viol_addr2), .viol_src(viol_src2), .viol_rgn(viol_rgn2),
        .viol_vld(viol_vld2), .viol_clr(viol_clr)
`endif
    );

    logic [AW-1:0] b_er_min[N], b_er_max[N], b_pr_min[N], b_pr_max[N];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] pc, input logic [15:0] da, input logic de,
                         input logic [15:0] ma, input logic me, input logic [3:0] ren);
        bus.pc = pc; bus.data_addr = da; bus.data_en = de;
        bus.dma_addr = ma; bus.dma_en = me; region_en = ren;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a region is either mid-walk (prog) or attested (att) or neither.
    bit m_prog[N], m_att[N];
    int m_cnt, m_cnt2;

    task automatic model_reset();
        for (int r = 0; r < N; r++) begin m_prog[r] = 0; m_att[r] = 0; end
        m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_step(output logic [3:0] e_exec, output logic [3:0] e_viol);
        bit wr;
        e_viol = '0;
        for (int r = 0; r < N; r++) begin
            wr = (bus.data_en && bus.data_addr >= b_pr_min[r] && bus.data_addr <= b_pr_max[r]) ||
                 (bus.dma_en  && bus.dma_addr  >= b_pr_min[r] && bus.dma_addr  <= b_pr_max[r]);
            if (!region_en[r]) begin
                m_prog[r] = 0; m_att[r] = 0;
            end else if (m_att[r]) begin
                if (wr) begin m_att[r] = 0; e_viol[r] = 1'b1; end
                else if (bus.pc == b_er_min[r]) begin m_att[r] = 0; m_prog[r] = 1; end
            end else if (m_prog[r]) begin
                if (wr || bus.pc < b_er_min[r] || bus.pc > b_er_max[r]) begin
                    m_prog[r] = 0; e_viol[r] = 1'b1;
                end else if (bus.pc == b_er_max[r]) begin
                    m_prog[r] = 0; m_att[r] = 1;
                end
            end else if (bus.pc == b_er_min[r] && !wr) begin
                m_prog[r] = 1;
            end
        end
        for (int r = 0; r < N; r++) e_exec[r] = m_att[r];
        if (e_viol != 0) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] da;
        logic        de;
        logic [15:0] ma;
        logic        me;
        logic [3:0]  ren;
        logic [3:0]  exec;
        logic [3:0]  viol;
        logic [7:0]  cnt;
        logic [1:0]  cnt2;
    } vec_t;

    function automatic vec_t mk(logic [15:0] pc, logic [15:0] da, logic de, logic [15:0] ma,
                                logic me, logic [3:0] ren, logic [3:0] ex, logic [3:0] vi,
                                logic [7:0] cnt, logic [1:0] cnt2);
        vec_t v;
        v.pc = pc; v.da = da; v.de = de; v.ma = ma; v.me = me; v.ren = ren;
        v.exec = ex; v.viol = vi; v.cnt = cnt; v.cnt2 = cnt2;
        return v;
    endfunction

    function automatic logic [15:0] pick_addr();
        int k;
        k = $urandom_range(0, 4);
        if (k < N) return 16'(b_pr_min[k] + ($urandom % (32'(b_pr_max[k] - b_pr_min[k]) + 1)));
        return 16'($urandom);
    endfunction

    vec_t tbl[24];

    initial begin
        logic [3:0]  ee, ev;
        logic [15:0] cur_pc;
        int          r;

        b_er_min = '{16'hE000, 16'h1000, 16'h2000, 16'h3000};
        b_er_max = '{16'hE010, 16'h1000, 16'h2002, 16'h3005};
        b_pr_min = '{16'hFFE0, 16'h0200, 16'h0100, 16'h8000};
        b_pr_max = '{16'hFFFF, 16'h02FF, 16'h0200, 16'h8FFF};
        for (int i = 0; i < N; i++) begin
            er_min_flat[i*AW +: AW] = b_er_min[i];
            er_max_flat[i*AW +: AW] = b_er_max[i];
            pr_min_flat[i*AW +: AW] = b_pr_min[i];
            pr_max_flat[i*AW +: AW] = b_pr_max[i];
        end
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
        viol_clr = 1'b0;
`endif

        //         pc        da        de    ma        me    ren   exec  viol  cnt cnt2
        tbl[0]  = mk(16'hE010, 16'h0000, 1'b0, 16'hFFFE, 1'b1, 4'hF, 4'h0, 4'h1, 1, 1);
        tbl[1]  = mk(16'hE010, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 1, 1);
        tbl[2]  = mk(16'hE000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 1, 1);
        tbl[3]  = mk(16'h4000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h1, 2, 2);
        tbl[4]  = mk(16'hE000, 16'hFFE0, 1'b1, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 2, 2);
        tbl[5]  = mk(16'hE001, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 2, 2);
        tbl[6]  = mk(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 2, 2);
        tbl[7]  = mk(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h2, 4'h0, 2, 2);
        tbl[8]  = mk(16'h2000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h2, 4'h0, 2, 2);
        tbl[9]  = mk(16'h2001, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h2, 4'h0, 2, 2);
        tbl[10] = mk(16'h2002, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h6, 4'h0, 2, 2);
        tbl[11] = mk(16'h2002, 16'h0200, 1'b1, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h6, 3, 3);
        tbl[12] = mk(16'h3000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 3, 3);
        tbl[13] = mk(16'h3001, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 4'h0, 3, 3);
        tbl[14] = mk(16'h3002, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 3, 3);
        tbl[15] = mk(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 3, 3);
        tbl[16] = mk(16'h1001, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h2, 4, 3);
        tbl[17] = mk(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 4, 3);
        tbl[18] = mk(16'h1001, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h2, 5, 3);
        tbl[19] = mk(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 5, 3);
        tbl[20] = mk(16'h1000, 16'h0250, 1'b1, 16'h0260, 1'b1, 4'hF, 4'h0, 4'h2, 6, 3);
        tbl[21] = mk(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h0, 6, 3);
        tbl[22] = mk(16'h1000, 16'h0300, 1'b1, 16'h00FF, 1'b1, 4'hF, 4'h2, 4'h0, 6, 3);
        tbl[23] = mk(16'h1000, 16'h02FF, 1'b1, 16'h0000, 1'b0, 4'hF, 4'h0, 4'h2, 7, 3);

        // Power-on reset
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        check("rst_exec", 32'(exec), 0);
        check("rst_viol", 32'(viol), 0);
        check("rst_cnt", 32'(viol_cnt), 0);
        check("rst_cnt2", 32'(viol_cnt2), 0);
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
        check("rst_vld", 32'(viol_vld), 0);
`endif
        $display("txn reset exec=%b viol=%b cnt=%0d", exec, viol, viol_cnt);
        @(negedge clk);
        rst = 1'b0;

        // Region 0 walk: attested the cycle after pc reaches er_max
        for (int a = 0; a <= 16; a++) begin
            drive(16'(32'hE000 + a), 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF);
            tick();
            check("walk_exec", 32'(exec), (a == 16) ? 32'h1 : 32'h0);
            check("walk_viol", 32'(viol), 0);
            $display("txn walk pc=%h exec=%b viol=%b cnt=%0d", bus.pc, exec, viol, viol_cnt);
        end

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].pc, tbl[i].da, tbl[i].de, tbl[i].ma, tbl[i].me, tbl[i].ren);
            tick();
            check($sformatf("tbl%0d_exec", i), 32'(exec), 32'(tbl[i].exec));
            check($sformatf("tbl%0d_viol", i), 32'(viol), 32'(tbl[i].viol));
            check($sformatf("tbl%0d_cnt", i), 32'(viol_cnt), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_cnt2", i), 32'(viol_cnt2), 32'(tbl[i].cnt2));
`ifdef MEM_PROTECT_VIOL_CAPTURE_EN
            if (i == 0 || i == 3) begin
                check("cap_vld", 32'(viol_vld), 1);
                check("cap_addr", 32'(viol_addr), 32'hFFFE);
                check("cap_src", 32'(viol_src), 1);
                check("cap_rgn", 32'(viol_rgn), 0);
            end
`endif
            $display("txn tbl%0d pc=%h exec=%b viol=%b cnt=%0d cnt2=%0d",
                     i, bus.pc, exec, viol, viol_cnt, viol_cnt2);
        end

        // Asynchronous reset with region 1 attested and region 3 mid-walk
        drive(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF); tick();
        drive(16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF); tick();
        drive(16'h3000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF); tick();
        drive(16'h3001, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF); tick();
        check("pre_rst_exec", 32'(exec), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("arst_exec", 32'(exec), 0);
        check("arst_viol", 32'(viol), 0);
        check("arst_cnt", 32'(viol_cnt), 0);
        check("arst_cnt2", 32'(viol_cnt2), 0);
        $display("txn async_reset exec=%b cnt=%0d", exec, viol_cnt);
        #1 rst = 1'b0;
        drive(16'h3005, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'hF);
        tick();
        check("post_rst_exec", 32'(exec), 0);
        $display("txn post_reset pc=%h exec=%b", bus.pc, exec);

        // Random traffic against the model
        rst = 1'b1;
        #3 rst = 1'b0;
        model_reset();
        cur_pc = 16'hE000;
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 15);
            if (r < 10)       cur_pc = cur_pc + 16'd1;
            else if (r < 13)  cur_pc = b_er_min[$urandom_range(0, N - 1)];
            else if (r == 14) cur_pc = 16'($urandom);
            drive(cur_pc,
                  pick_addr(), ($urandom_range(0, 7) == 0),
                  pick_addr(), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'hF);
            model_step(ee, ev);
            tick();
            check("rnd_exec", 32'(exec), 32'(ee));
            check("rnd_viol", 32'(viol), 32'(ev));
            check("rnd_cnt", 32'(viol_cnt), 32'(m_cnt));
            check("rnd_cnt2", 32'(viol_cnt2), 32'(m_cnt2));
            $display("txn rnd%0d pc=%h exec=%b viol=%b cnt=%0d cnt2=%0d",
                     k, bus.pc, exec, viol, viol_cnt, viol_cnt2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
